// File: rtl/debounce_event_sync_if.sv
// Signal bundle between the raw button source/consumer and the debounce_event_sync stage.
// master: drives raw_in/clr and observes results; slave: the debouncer itself.
interface debounce_event_sync_if;
  logic raw_in;
  logic clr;
  logic w_level;
  logic w_rise;
  logic w_fall;
  logic w_event;
  logic w_overrun;

  modport master (
    output raw_in, clr,
    input  w_level, w_rise, w_fall, w_event, w_overrun
  );

  modport slave (
    input  raw_in, clr,
    output w_level, w_rise, w_fall, w_event, w_overrun
  );
endinterface

// File: rtl/debounce_event_sync.sv
// Synchronise, debounce and latch events from a raw button feeding the 1 Hz sequence detector.
// Optional build macro DEBOUNCE_ACTIVE_LOW_EN: invert raw_in for active-low buttons.
module debounce_event_sync #(
  parameter int CNT_MAX = 1000000
) (
  input  logic                  clk_50m,
  input  logic                  reset,
  debounce_event_sync_if.slave  bus
);

  localparam int              CNT_W    = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
  localparam logic SYNC_RST = 1'b1;
  logic raw_cond;
  assign raw_cond = ~bus.raw_in;
`else
  localparam logic SYNC_RST = 1'b0;
  logic raw_cond;
  assign raw_cond = bus.raw_in;
`endif

  logic             s1, s2;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_q, level_nxt;
  logic             rise_q, rise_nxt;
  logic             fall_q, fall_nxt;
  logic             event_q, event_nxt;
  logic             overrun_q, overrun_nxt;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level_q;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;

    case (state)
      IDLE_LOW: begin
        if (s2) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_nxt = IDLE_LOW;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s2) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_nxt = IDLE_HIGH;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        level_nxt = 1'b0;
      end
    endcase

    // A new rise beats a simultaneous clr so the event is never lost.
    event_nxt   = rise_nxt | (event_q & ~bus.clr);
    overrun_nxt = (rise_nxt & event_q & ~bus.clr) | (overrun_q & ~bus.clr);
  end

  // NOTE: state registers use non-blocking assignments so s1->s2 shifts by one flop per edge.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      s1        <= SYNC_RST;
      s2        <= SYNC_RST;
      state     <= IDLE_LOW;
      cnt       <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      event_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      s1        <= raw_cond;
      s2        <= s1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      level_q   <= level_nxt;
      rise_q    <= rise_nxt;
      fall_q    <= fall_nxt;
      event_q   <= event_nxt;
      overrun_q <= overrun_nxt;
    end
  end

  assign bus.w_level   = level_q;
  assign bus.w_rise    = rise_q;
  assign bus.w_fall    = fall_q;
  assign bus.w_event   = event_q;
  assign bus.w_overrun = overrun_q;

endmodule

// File: tb/tb_debounce_event_sync.sv
// Directed self-checking bench for debounce_event_sync with CNT_MAX=4 (accept edge = 7 after a change).
// Pressed/released pin levels follow DEBOUNCE_ACTIVE_LOW_EN when it is defined.
module tb_debounce_event_sync;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
  localparam logic PRESS = 1'b0;
`else
  localparam logic PRESS = 1'b1;
`endif
  localparam logic REL = ~PRESS;

  logic clk_50m = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  debounce_event_sync_if dif ();

  debounce_event_sync #(.CNT_MAX(4)) dut (
    .clk_50m (clk_50m),
    .reset   (reset),
    .bus     (dif)
  );

  always #10 clk_50m = ~clk_50m;

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  task automatic check(input string tag, input logic observed, input logic expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_outs(input string tag, input logic lvl, input logic r, input logic f,
                            input logic ev, input logic ov);
    check({tag, ".level"},   dif.w_level,   lvl);
    check({tag, ".rise"},    dif.w_rise,    r);
    check({tag, ".fall"},    dif.w_fall,    f);
    check({tag, ".event"},   dif.w_event,   ev);
    check({tag, ".overrun"}, dif.w_overrun, ov);
  endtask

  initial begin
    reset      = 1'b1;
    dif.raw_in = REL;
    dif.clr    = 1'b0;
    tick(2);
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(4);
    check_outs("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean press: accept at edge 7 after the change.
    dif.raw_in = PRESS;
    tick(6);
    check_outs("press_e6", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_outs("press_e7", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    check_outs("press_e8", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(12);
    check_outs("press_hold", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Release: fall at edge 7, w_event untouched.
    dif.raw_in = REL;
    tick(6);
    check_outs("release_e6", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    check_outs("release_e7", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    check_outs("release_e8", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Bounce 1,0,1,0 at 2 cycles each: nothing may come out.
    for (int k = 0; k < 4; k++) begin
      dif.raw_in = (k % 2 == 0) ? PRESS : REL;
      for (int e = 0; e < 2; e++) begin
        tick(1);
        check("bounce.rise", dif.w_rise, 1'b0);
        check("bounce.fall", dif.w_fall, 1'b0);
      end
    end
    dif.raw_in = PRESS;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      check("settle.rise", dif.w_rise, 1'b0);
      check("settle.fall", dif.w_fall, 1'b0);
    end
    // Second press without clr: overrun latches.
    tick(1);
    check_outs("bounce_accept", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

    // clr pulse clears both sticky flags.
    dif.clr = 1'b1;
    tick(1);
    dif.clr = 1'b0;
    check_outs("clr_pulse", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Press whose accept edge coincides with clr: event still set.
    dif.raw_in = REL;
    tick(10);
    check_outs("rel2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dif.raw_in = PRESS;
    tick(6);
    dif.clr = 1'b1;
    tick(1);
    dif.clr = 1'b0;
    check_outs("clr_with_rise", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Rise with clr while w_event already 1: overrun must stay clear.
    dif.raw_in = REL;
    tick(10);
    dif.raw_in = PRESS;
    tick(6);
    check("pre_ovr.event", dif.w_event, 1'b1);
    dif.clr = 1'b1;
    tick(1);
    dif.clr = 1'b0;
    check_outs("clr_blocks_ovr", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset during WAIT_HIGH with cnt=2, then full latency again.
    dif.raw_in = REL;
    tick(10);
    check_outs("rel3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    dif.raw_in = PRESS;
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_outs("mid_wait_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(6);
    check_outs("post_reset_e6", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_outs("post_reset_e7", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    check("post_reset_e8.rise", dif.w_rise, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
